// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM encodings and width defaults shared by ALU control and execute
package alu_pkg;

  localparam int ALU_DATA_WIDTH  = 32;
  localparam int ALU_SHAMT_WIDTH = 5;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_OR     = 4'b0010;
  localparam logic [3:0] OP_AND    = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0100;
  localparam logic [3:0] OP_SLL    = 4'b0101;
  localparam logic [3:0] OP_SRL    = 4'b0110;
  localparam logic [3:0] OP_PASS_B = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - bit-serial shifter: one position per cycle, counts the amount down to zero
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = ALU_SHAMT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   dir,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic [DATA_WIDTH-1:0]  acc,
  output logic                   busy,
  output logic                   last
);

  logic [DATA_WIDTH-1:0]  acc_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   dir_q;

  // dir = 1 is a logical right shift, 0 is a left shift; both zero-fill
  always_comb begin
    acc = dir_q ? (acc_q >> 1) : (acc_q << 1);
  end

  assign busy = (cnt_q != '0);
  assign last = (cnt_q == SHAMT_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      acc_q <= data;
      cnt_q <= shamt;
      dir_q <= dir;
    end else if (busy) begin
      acc_q <= acc;
      cnt_q <= cnt_q - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute stage: single-cycle logic/add/sub, bit-serial shifts, registered result
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = ALU_SHAMT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  done_o
);

  alu_state_e             state_q, state_d;
  logic                   accept;
  logic                   start_shift;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  comb_result;
  logic [DATA_WIDTH-1:0]  shift_acc;
  logic                   shift_busy;
  logic                   shift_last;

  assign shamt       = operand_b_i[SHAMT_WIDTH-1:0];
  assign accept      = valid_i & ready_o;
  assign start_shift = accept & is_shift_op(alu_operation_i) & (shamt != '0);

  // Shifts only reach this path with a zero amount, where the result is A unchanged
  always_comb begin
    comb_result = '0;
    case (alu_operation_i)
      OP_ADD:    comb_result = operand_a_i + operand_b_i;
      OP_SUB:    comb_result = operand_a_i - operand_b_i;
      OP_OR:     comb_result = operand_a_i | operand_b_i;
      OP_AND:    comb_result = operand_a_i & operand_b_i;
      OP_XOR:    comb_result = operand_a_i ^ operand_b_i;
      OP_SLL:    comb_result = operand_a_i;
      OP_SRL:    comb_result = operand_a_i;
      OP_PASS_B: comb_result = operand_b_i;
      default:   comb_result = '0;
    endcase
  end

  alu_shift_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shift_iter (
    .clk  (clk),
    .reset(reset),
    .load (start_shift),
    .dir  (alu_operation_i == OP_SRL),
    .shamt(shamt),
    .data (operand_a_i),
    .acc  (shift_acc),
    .busy (shift_busy),
    .last (shift_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_shift)  state_d = ST_SHIFT;
        else if (accept)  state_d = ST_DONE;
        else              state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (shift_last)       state_d = ST_DONE;
        else if (!shift_busy) state_d = ST_IDLE;
        else                  state_d = ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b1;
    done_o  = 1'b0;
    case (state_q)
      ST_SHIFT: ready_o = 1'b0;
      ST_DONE:  done_o  = 1'b1;
      default: begin
        ready_o = 1'b1;
        done_o  = 1'b0;
      end
    endcase
  end

  // Result and zero flag only move on the edge that enters DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_o <= '0;
      zero_o   <= 1'b1;
    end else if (accept && !start_shift) begin
      result_o <= comb_result;
      zero_o   <= (comb_result == '0);
    end else if (state_q == ST_SHIFT && shift_last) begin
      result_o <= shift_acc;
      zero_o   <= (shift_acc == '0);
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed-vector bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  alu_operation_i = 4'd0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        done_o;

  int checks = 0;
  int failures = 0;

  alu_exec_unit dut (
    .clk            (clk),
    .reset          (reset),
    .alu_operation_i(alu_operation_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .result_o       (result_o),
    .zero_o         (zero_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i         = 1'b1;
    alu_operation_i = op;
    operand_a_i     = a;
    operand_b_i     = b;
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b);
    @(negedge clk);
    valid_i = 1'b0;
    check({tag, ".done"}, 32'(done_o), 32'd1);
    check({tag, ".result"}, result_o, exp);
    check({tag, ".zero"}, 32'(zero_o), 32'(exp == 32'd0));
    check({tag, ".ready"}, 32'(ready_o), 32'd1);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done_o), 32'd0);
    check({tag, ".hold"}, result_o, exp);
  endtask

  // pulse_add: present an ADD for one cycle while the shift is in flight
  task automatic run_shift(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int s, input logic [31:0] exp,
                           input bit pulse_add);
    int cycles;
    int low;
    int extra;
    cycles = 0;
    low    = 0;
    extra  = 0;
    drive(op, a, b);
    @(negedge clk);
    valid_i = 1'b0;
    while (!done_o && cycles < 40) begin
      if (!ready_o) low++;
      if (pulse_add && cycles == 1) drive(4'b0000, 32'd1, 32'd2);
      if (pulse_add && cycles == 2) valid_i = 1'b0;
      @(negedge clk);
      cycles++;
    end
    valid_i = 1'b0;
    check({tag, ".latency"}, 32'(cycles), 32'(s));
    check({tag, ".ready_low"}, 32'(low), 32'(s));
    check({tag, ".result"}, result_o, exp);
    check({tag, ".zero"}, 32'(zero_o), 32'(exp == 32'd0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    check({tag, ".extra_done"}, 32'(extra), 32'd0);
    check({tag, ".hold"}, result_o, exp);
  endtask

  initial begin
    int late_done;
    repeat (2) @(negedge clk);
    check("rst.result", result_o, 32'd0);
    check("rst.zero", 32'(zero_o), 32'd1);
    check("rst.done", 32'(done_o), 32'd0);
    check("rst.ready", 32'(ready_o), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // back-to-back ADD then SUB with valid held
    drive(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    drive(4'b0001, 32'd5, 32'd5);
    check("b2b.add.done", 32'(done_o), 32'd1);
    check("b2b.add.result", result_o, 32'h8000_0000);
    check("b2b.add.zero", 32'(zero_o), 32'd0);
    check("b2b.add.ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    valid_i = 1'b0;
    check("b2b.sub.done", 32'(done_o), 32'd1);
    check("b2b.sub.result", result_o, 32'd0);
    check("b2b.sub.zero", 32'(zero_o), 32'd1);
    @(negedge clk);
    check("b2b.idle.done", 32'(done_o), 32'd0);

    run_single("or",     4'b0010, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    run_single("and",    4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    run_single("xor",    4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    run_single("sub_wrap", 4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF);
    run_single("srl0",   4'b0110, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF);
    run_single("sll_b_hi", 4'b0101, 32'h0000_0003, 32'hFFFF_FFE0, 32'h0000_0003);
    run_single("op1010", 4'b1010, 32'h1234_5678, 32'h0000_0001, 32'd0);
    run_single("pass_b", 4'b0111, 32'hFFFF_FFFF, 32'h1234_5000, 32'h1234_5000);

    run_shift("sll4",   4'b0101, 32'h0000_0001, 32'd4,  4,  32'h0000_0010, 1'b0);
    run_shift("srl31",  4'b0110, 32'h8000_0000, 32'd31, 31, 32'h0000_0001, 1'b0);
    run_shift("sll31",  4'b0101, 32'h0000_0001, 32'd31, 31, 32'h8000_0000, 1'b0);
    run_shift("srl_out", 4'b0110, 32'h0000_0003, 32'd2, 2,  32'h0000_0000, 1'b0);
    run_shift("pulse",  4'b0110, 32'hF000_0000, 32'd4,  4,  32'h0F00_0000, 1'b1);

    // reset in the middle of a 20-step shift; result_o is non-zero going in
    drive(4'b0101, 32'h0000_0001, 32'd20);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst.busy", 32'(ready_o), 32'd0);
    check("midrst.pre_result", result_o, 32'h0F00_0000);
    reset = 1'b1;
    #1;
    check("midrst.result", result_o, 32'd0);
    check("midrst.zero", 32'(zero_o), 32'd1);
    check("midrst.done", 32'(done_o), 32'd0);
    check("midrst.ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    late_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_o) late_done++;
    end
    check("midrst.no_done", 32'(late_done), 32'd0);
    check("midrst.result_hold", result_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
